// File: rtl/timer_scheduler_if.sv
// Request/grant bus between timer clients and the shared timer_scheduler.
// master = requester side, slave = scheduler side.
interface timer_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32
);
  logic [NUM_REQ-1:0]       Req;
  logic [NUM_REQ*WIDTH-1:0] Delay;
  logic [NUM_REQ-1:0]       Grant;
  logic [NUM_REQ-1:0]       Done;
  logic                     Busy;

  modport master (output Req, Delay, input Grant, Done, Busy);
  modport slave  (input Req, Delay, output Grant, Done, Busy);
endinterface

// File: rtl/timer_scheduler.sv
// One countdown timer shared round-robin among NUM_REQ requesters.
// Optional macro TIMER_PRESCALE_EN: Count decrements once every PRESCALE clocks.
module timer_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PRESCALE = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  timer_scheduler_if.slave   bus
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 16 || WIDTH < 1 || PRESCALE < 1) begin : g_bad_params
    $error("timer_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, COUNT, RELEASE} state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] grant, grant_n;
  logic [NUM_REQ-1:0] done, done_n;
  logic [WIDTH-1:0]   count, count_n;
  logic [IW-1:0]      ptr, ptr_n;
  logic [IW-1:0]      owner, owner_n;
  logic [IW-1:0]      owner_inc;
  logic [IW-1:0]      pick;
  logic               found;

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] presc, presc_n;
`endif

  assign owner_inc = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // First requester at or after ptr, scanning modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.Req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    done_n  = '0;
    count_n = count;
    ptr_n   = ptr;
    owner_n = owner;
`ifdef TIMER_PRESCALE_EN
    presc_n = presc;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          grant_n       = '0;
          grant_n[pick] = 1'b1;
          owner_n       = pick;
          count_n       = bus.Delay[int'(pick)*int'(WIDTH) +: WIDTH];
          state_n       = COUNT;
`ifdef TIMER_PRESCALE_EN
          presc_n       = '0;
`endif
        end
      end
      COUNT: begin
        if (!bus.Req[owner]) begin
          grant_n = '0;
          ptr_n   = owner_inc;
          state_n = IDLE;
`ifdef TIMER_PRESCALE_EN
          presc_n = '0;
`endif
        end else if (count == '0) begin
          done_n[owner] = 1'b1;
          grant_n       = '0;
          ptr_n         = owner_inc;
          state_n       = RELEASE;
        end else begin
`ifdef TIMER_PRESCALE_EN
          if (presc == PW'(PRESCALE - 1)) begin
            count_n = count - 1'b1;
            presc_n = '0;
          end else begin
            presc_n = presc + 1'b1;
          end
`else
          count_n = count - 1'b1;
`endif
        end
      end
      RELEASE: begin
        if (!bus.Req[owner]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      grant <= '0;
      done  <= '0;
      count <= '0;
      ptr   <= '0;
      owner <= '0;
`ifdef TIMER_PRESCALE_EN
      presc <= '0;
`endif
    end else begin
      state <= state_n;
      grant <= grant_n;
      done  <= done_n;
      count <= count_n;
      ptr   <= ptr_n;
      owner <= owner_n;
`ifdef TIMER_PRESCALE_EN
      presc <= presc_n;
`endif
    end
  end

  assign bus.Grant = grant;
  assign bus.Done  = done;
  assign bus.Busy  = (state != IDLE);
endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler (NUM_REQ=4, WIDTH=8, PRESCALE=4): per-cycle vector
// table plus hand-written sequences for round-robin, max delay, reset and prescale latency.
module tb_timer_scheduler;
`ifdef TIMER_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic Clock;
  logic Reset;
  int   checks = 0;
  int   passed = 0;
  int   viol   = 0;

  timer_scheduler_if #(.NUM_REQ(4), .WIDTH(8)) bus();

  timer_scheduler #(.NUM_REQ(4), .WIDTH(8), .PRESCALE(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Owner exclusivity: never two grant bits, never grant and done on different indices.
  always @(negedge Clock) begin
    if (!$onehot0(bus.Grant) || (bus.Grant != 4'd0 && bus.Done != 4'd0 && bus.Grant != bus.Done))
      viol++;
  end

  typedef struct {
    string      nm;
    logic [3:0] req;
    logic [31:0] delay;
    logic [3:0] grant;
    logic [3:0] done;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string nm, input logic [3:0] r, input logic [31:0] d,
                              input logic [3:0] g, input logic [3:0] dn, input logic b);
    vec_t v;
    v.nm = nm; v.req = r; v.delay = d; v.grant = g; v.done = dn; v.busy = b;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Single request on slot idx with delay d; Delay is scrambled after the grant edge.
  task automatic run_delay(input int idx, input logic [7:0] d, input string nm);
    int         exp_lat;
    int         lat;
    logic [3:0] b;
    exp_lat = int'(d) * P + 1;
    lat     = 0;
    b       = 4'b0001 << idx;
    bus.Delay[idx*8 +: 8] = d;
    bus.Req = b;
    step();
    check({nm, "_grant"}, 32'(bus.Grant), 32'(b));
    bus.Delay[idx*8 +: 8] = 8'h01;
    for (int c = 1; c <= exp_lat + 20; c++) begin
      step();
      if (bus.Done != 4'd0) begin
        lat = c;
        break;
      end
    end
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_done"}, 32'({bus.Grant, bus.Done}), 32'({4'd0, b}));
    step();
    check({nm, "_release"}, 32'({bus.Busy, bus.Done, bus.Grant}), 32'({1'b1, 8'd0}));
    bus.Req = 4'd0;
    step();
    check({nm, "_idle"}, 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    int         order[$];
    int         exp_order[5];
    int         dcnt[4];
    int         stray;
    logic [3:0] prevg, drop_pend, raise_pend, nreq;
    logic       rearmed;

    exp_order = '{0, 1, 2, 3, 0};
    Reset = 1'b1;
    bus.Req = 4'd0;
    bus.Delay = '0;
    step();
    step();
    check("reset_outputs", 32'({bus.Grant, bus.Done, bus.Busy}), 32'd0);
    Reset = 1'b0;

    // Single request, delay 5 on slot 0
    add("t1_grant", 4'b0001, 32'h0000_0005, 4'b0001, 4'b0000, 1'b1);
    for (int k = 1; k <= 5 * P; k++)
      add("t1_count", 4'b0001, 32'h0000_0005, 4'b0001, 4'b0000, 1'b1);
    add("t1_done",    4'b0001, 32'h0000_0005, 4'b0000, 4'b0001, 1'b1);
    add("t1_release", 4'b0001, 32'h0000_0005, 4'b0000, 4'b0000, 1'b1);
    add("t1_idle",    4'b0000, 32'h0000_0005, 4'b0000, 4'b0000, 1'b0);
    add("idle_noreq", 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0);
    // Zero delay on slot 1
    add("t2_zero_grant", 4'b0010, 32'h0, 4'b0010, 4'b0000, 1'b1);
    add("t2_zero_done",  4'b0010, 32'h0, 4'b0000, 4'b0010, 1'b1);
    add("t2_zero_idle",  4'b0000, 32'h0, 4'b0000, 4'b0000, 1'b0);
    // Abort of slot 2 (delay 10); Req[3] arrives during the abort cycle
    add("t4_grant", 4'b0100, 32'h000A_0000, 4'b0100, 4'b0000, 1'b1);
    for (int k = 1; k <= 4; k++)
      add("t4_count", 4'b0100, 32'h000A_0000, 4'b0100, 4'b0000, 1'b1);
    add("t4_abort",      4'b1000, 32'h000A_0000, 4'b0000, 4'b0000, 1'b0);
    add("t4_next_grant", 4'b1000, 32'h000A_0000, 4'b1000, 4'b0000, 1'b1);
    add("t4_next_done",  4'b1000, 32'h000A_0000, 4'b0000, 4'b1000, 1'b1);
    add("t4_idle",       4'b0000, 32'h000A_0000, 4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.Req   = vecs[i].req;
      bus.Delay = vecs[i].delay;
      step();
      check($sformatf("%s[%0d]", vecs[i].nm, i),
            32'({bus.Grant, bus.Done, bus.Busy}),
            32'({vecs[i].grant, vecs[i].done, vecs[i].busy}));
    end

    // Round-robin: all request, each drops one cycle after its Done, slot 0 re-requests
    bus.Delay  = 32'h0303_0303;
    bus.Req    = 4'b1111;
    prevg      = 4'd0;
    drop_pend  = 4'd0;
    raise_pend = 4'd0;
    rearmed    = 1'b0;
    for (int i = 0; i < 4; i++) dcnt[i] = 0;
    for (int c = 0; c < 500 && order.size() < 5; c++) begin
      step();
      if (bus.Grant != 4'd0 && bus.Grant != prevg) order.push_back(oh2i(bus.Grant));
      prevg = bus.Grant;
      if (bus.Done != 4'd0) dcnt[oh2i(bus.Done)]++;
      nreq = (bus.Req & ~drop_pend) | raise_pend;
      raise_pend = 4'd0;
      if (drop_pend[0] && !rearmed) begin
        raise_pend = 4'b0001;
        rearmed    = 1'b1;
      end
      drop_pend = bus.Done;
      bus.Req   = nreq;
    end
    check("rr_grant_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < order.size() && i < 5; i++)
      check($sformatf("rr_order[%0d]", i), 32'(order[i]), 32'(exp_order[i]));
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_done_count[%0d]", i), 32'(dcnt[i]), 32'd1);
    bus.Req = 4'd0;
    step();
    step();
    check("rr_drain_idle", 32'(bus.Busy), 32'd0);

    // Maximum delay on slot 1 (leaves the pointer at 2)
    bus.Delay = '0;
    run_delay(1, 8'd255, "t2_max");

    // Reset in the middle of a countdown
    bus.Delay = 32'h0000_0014;
    bus.Req   = 4'b0001;
    step();
    check("t5_grant", 32'(bus.Grant), 32'h1);
    for (int k = 1; k <= 6; k++) step();
    Reset = 1'b1;
    step();
    check("t5_reset_outputs", 32'({bus.Grant, bus.Done, bus.Busy}), 32'd0);
    Reset   = 1'b0;
    bus.Req = 4'd0;
    stray   = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.Done != 4'd0) stray++;
    end
    check("t5_no_done_after_reset", 32'(stray), 32'd0);
    bus.Delay = 32'h0000_0000;
    bus.Req   = 4'b1001;
    step();
    check("t5_ptr_restart_grant", 32'(bus.Grant), 32'h1);
    step();
    check("t5_ptr_restart_done", 32'(bus.Done), 32'h1);
    bus.Req = 4'd0;
    step();
    check("t5_idle", 32'(bus.Busy), 32'd0);

    // Prescale-dependent latency with delay 3
    run_delay(2, 8'd3, "t6_prescale");

    check("grant_done_exclusive", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
